// File: rtl/parity_tx_pkg.sv
// Shared types, frame constants and parity helper for the parity serial transmitter.
package parity_tx_pkg;

  localparam int unsigned DATA_W_DEF   = 8;
  localparam int unsigned FRAME_BITS   = DATA_W_DEF + 3;
  localparam int unsigned PARITY_MAX_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Zero-extension of narrower payloads leaves the reduction unchanged.
  function automatic logic calc_parity(input logic [PARITY_MAX_W-1:0] data,
                                       input logic                    odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/parity_serial_tx_baud_tick_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module baud_tick_gen #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  output logic             bit_tick,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear || bit_tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_tick = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign count    = cnt_q;

endmodule

// File: rtl/parity_serial_tx.sv
// Byte-to-serial framer: start(0), LSB-first data, parity, stop(1); registered line outputs.
module parity_serial_tx
  import parity_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              parity_q, parity_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              tx_done_q, tx_done_d;
  logic              data_ready_q, data_ready_d;

  logic              bit_tick;
  logic [CNT_W-1:0]  baud_cnt;
  logic              baud_clear_c;
  logic              accept_c;
  logic              last_bit_c;

  assign baud_clear_c = (state_q == ST_IDLE);
  assign accept_c     = data_valid && data_ready_q;
  assign last_bit_c   = (bit_cnt_q == BIT_W'(DATA_W - 1));

  baud_tick_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clear    (baud_clear_c),
    .bit_tick (bit_tick),
    .count    (baud_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept_c)                 state_d = ST_START;
      ST_START:  if (bit_tick)                 state_d = ST_DATA;
      ST_DATA:   if (bit_tick && last_bit_c)   state_d = ST_PARITY;
      ST_PARITY: if (bit_tick)                 state_d = ST_STOP;
      ST_STOP:   if (bit_tick)                 state_d = ST_IDLE;
      default:                                 state_d = ST_IDLE;
    endcase
  end

  // Datapath and line outputs are computed from the next state so they register in step with it.
  always_comb begin
    shift_d   = shift_q;
    parity_d  = parity_q;
    bit_cnt_d = bit_cnt_q;
    if (accept_c) begin
      shift_d  = data_in;
      parity_d = calc_parity(PARITY_MAX_W'(data_in), 1'(PARITY_ODD));
    end
    if (state_q == ST_IDLE) begin
      bit_cnt_d = '0;
    end else if ((state_q == ST_DATA) && bit_tick) begin
      shift_d   = shift_q >> 1;
      bit_cnt_d = last_bit_c ? '0 : bit_cnt_q + BIT_W'(1);
    end

    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = parity_d;
      default:   tx_d = 1'b1;
    endcase

    busy_d       = (state_d != ST_IDLE);
    data_ready_d = (state_d == ST_IDLE);
    // Registered pulse lands in the final cycle of the stop bit.
    tx_done_d    = (state_q == ST_STOP) && (baud_cnt == CNT_W'(CLKS_PER_BIT - 2));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q      <= '0;
      parity_q     <= 1'b0;
      bit_cnt_q    <= '0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      tx_done_q    <= 1'b0;
      data_ready_q <= 1'b1;
    end else begin
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      bit_cnt_q    <= bit_cnt_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      tx_done_q    <= tx_done_d;
      data_ready_q <= data_ready_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign tx_done    = tx_done_q;
  assign data_ready = data_ready_q;

endmodule

// File: tb/tb_parity_serial_tx.sv
// Directed bench for parity_serial_tx: even and odd parity instances share one stimulus stream.
module tb_parity_serial_tx;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready, tx, busy, tx_done;
  logic       data_ready_o, tx_o, busy_o, tx_done_o;

  int n_assert = 0;
  int n_fail   = 0;

  parity_serial_tx #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY_ODD(0)) dut_even (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .tx(tx), .busy(busy), .tx_done(tx_done)
  );

  parity_serial_tx #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY_ODD(1)) dut_odd (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready_o), .tx(tx_o), .busy(busy_o), .tx_done(tx_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of frame cycle 1.
  task automatic send(input logic [7:0] d, input bit hold);
    chk("ready_before_send", 32'(data_ready), 32'd1);
    data_in    = d;
    data_valid = 1'b1;
    @(negedge clk);
    if (!hold) data_valid = 1'b0;
  endtask

  // Checks frame cycles 1..44 and the idle cycle 45; exp[0] is the start bit, exp[10] the stop bit.
  task automatic check_frame(input string tag, input logic [10:0] exp, input logic [10:0] exp_o,
                             input bit chk_o, input int pulse_k);
    for (int k = 1; k <= 44; k++) begin
      if (pulse_k != 0) begin
        if (k == pulse_k) begin
          data_in    = 8'hFF;
          data_valid = 1'b1;
        end else if (k == pulse_k + 1) begin
          data_valid = 1'b0;
        end
      end
      chk({tag, "_tx"},    32'(tx),         32'(exp[(k-1)/4]));
      chk({tag, "_done"},  32'(tx_done),    32'(k == 44));
      chk({tag, "_busy"},  32'(busy),       32'd1);
      chk({tag, "_ready"}, 32'(data_ready), 32'd0);
      if (chk_o) begin
        chk({tag, "_odd_tx"},   32'(tx_o),      32'(exp_o[(k-1)/4]));
        chk({tag, "_odd_done"}, 32'(tx_done_o), 32'(k == 44));
        chk({tag, "_odd_busy"}, 32'(busy_o),    32'd1);
        chk({tag, "_odd_rdy"},  32'(data_ready_o), 32'd0);
      end
      @(negedge clk);
    end
    chk({tag, "_end_tx"},    32'(tx),         32'd1);
    chk({tag, "_end_done"},  32'(tx_done),    32'd0);
    chk({tag, "_end_busy"},  32'(busy),       32'd0);
    chk({tag, "_end_ready"}, 32'(data_ready), 32'd1);
  endtask

  initial begin
    int done_seen;
    rst        = 1'b1;
    data_in    = 8'h00;
    data_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_tx",    32'(tx),         32'd1);
    chk("reset_busy",  32'(busy),       32'd0);
    chk("reset_done",  32'(tx_done),    32'd0);
    chk("reset_ready", 32'(data_ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // 0xAA: even parity 0, odd parity 1; data LSB-first 0,1,0,1,0,1,0,1
    send(8'hAA, 1'b0);
    check_frame("aa", 11'b1_0_10101010_0, 11'b1_1_10101010_0, 1'b1, 0);

    // 0xBA: data LSB-first 0,1,0,1,1,1,0,1; five ones so even parity 1
    @(negedge clk);
    send(8'hBA, 1'b0);
    check_frame("ba", 11'b1_1_10111010_0, 11'b1_0_10111010_0, 1'b0, 0);

    // Back-to-back with valid held; data_in changes mid-frame without effect
    @(negedge clk);
    send(8'hAA, 1'b1);
    data_in = 8'h55;
    check_frame("b2b_aa", 11'b1_0_10101010_0, 11'b1_1_10101010_0, 1'b0, 0);
    @(negedge clk);
    data_valid = 1'b0;
    chk("b2b_start_tx", 32'(tx), 32'd0);
    // Cycle 1 of the 0x55 frame already checked above; continue from the same cycle.
    check_frame("b2b_55", 11'b1_0_01010101_0, 11'b1_1_01010101_0, 1'b0, 0);

    // Valid pulse with 0xFF while busy is ignored
    @(negedge clk);
    send(8'h0F, 1'b0);
    check_frame("ignore", 11'b1_0_00001111_0, 11'b1_1_00001111_0, 1'b0, 20);
    @(negedge clk);
    chk("ignore_no_second_busy", 32'(busy), 32'd0);
    chk("ignore_no_second_tx",   32'(tx),   32'd1);

    // Reset during data bit 3 (frame cycles 17..20)
    @(negedge clk);
    send(8'h0F, 1'b0);
    for (int k = 1; k <= 18; k++) begin
      if (k < 18) @(negedge clk);
    end
    chk("pre_rst_tx_bit3", 32'(tx), 32'd1);
    chk("pre_rst_busy",    32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_tx",    32'(tx),         32'd1);
    chk("rst_mid_busy",  32'(busy),       32'd0);
    chk("rst_mid_ready", 32'(data_ready), 32'd1);
    chk("rst_mid_done",  32'(tx_done),    32'd0);
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (tx_done || !tx || busy) done_seen++;
    end
    chk("rst_no_activity", 32'(done_seen), 32'd0);

    send(8'hBA, 1'b0);
    check_frame("post_rst", 11'b1_1_10111010_0, 11'b1_0_10111010_0, 1'b1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
